// File: rtl/tm_lif_pkg.sv
// Shared constants, types and helpers for the time-multiplexed LIF neuron array.
package tm_lif_pkg;

    localparam int N_NEURONS_DEF  = 8;
    localparam int WIDTH_DEF      = 8;
    localparam int THRESH_RST_DEF = 127;

    // Refractory countdown, enough for 0..15 silent visits.
    typedef logic [3:0] refr_t;

    // Add two values and clamp the result to the largest w-bit number.
    // Operands are carried at 64 bits so a single function serves any WIDTH.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_v;
        logic [63:0] s;
        max_v = (64'd1 << w) - 64'd1;
        s     = a + b;
        return (s > max_v) ? max_v : s;
    endfunction

endpackage

// File: rtl/tm_lif_array_if.sv
// Bus between the current source / config master and the LIF neuron array.
interface tm_lif_array_if #(
    parameter int N_NEURONS = 8,
    parameter int WIDTH     = 8
);
    localparam int SLOT_W = $clog2(N_NEURONS);

    logic                 en;
    logic [WIDTH-1:0]     current;
    logic                 cfg_we;
    logic [SLOT_W-1:0]    cfg_addr;
    logic [WIDTH-1:0]     cfg_thresh;
    logic [N_NEURONS-1:0] spike;
    logic [SLOT_W-1:0]    slot;
    logic                 sweep_done;

    modport master (
        output en, current, cfg_we, cfg_addr, cfg_thresh,
        input  spike, slot, sweep_done
    );

    modport slave (
        input  en, current, cfg_we, cfg_addr, cfg_thresh,
        output spike, slot, sweep_done
    );

endinterface

// File: rtl/tm_lif_array_update.sv
// Combinational next-state of one LIF neuron: leak, saturating integrate,
// threshold compare, reset-to-zero on fire and refractory countdown.
module lif_update
    import tm_lif_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2
) (
    input  logic [WIDTH-1:0] mem,
    input  refr_t            refr,
    input  logic [WIDTH-1:0] thresh,
    input  logic [WIDTH-1:0] current,
    output logic [WIDTH-1:0] mem_nxt,
    output refr_t            refr_nxt,
    output logic             fire
);

    logic [WIDTH-1:0] leaked;
    logic [63:0]      sum;

    assign leaked = mem >> LEAK_SHIFT;
    assign sum    = sat_add(64'(current), 64'(leaked), WIDTH);

    // Refractory neurons are held at zero; otherwise integrate and compare.
    always_comb begin
        mem_nxt  = '0;
        refr_nxt = '0;
        fire     = 1'b0;
        if (refr != '0) begin
            refr_nxt = refr_t'(refr - refr_t'(1));
        end else if (sum >= 64'(thresh)) begin
            fire     = 1'b1;
            refr_nxt = refr_t'(REFRACT);
        end else begin
            mem_nxt = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tm_lif_array.sv
// Time-multiplexed leaky-integrate-and-fire array: one shared update datapath
// visits the neurons round-robin, one per enabled clock.
module tm_lif_array
    import tm_lif_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2,
    parameter int THRESH_RST = THRESH_RST_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    tm_lif_array_if.slave  bus
);

    localparam int SLOT_W = $clog2(N_NEURONS);

    logic [WIDTH-1:0] membrane  [N_NEURONS];
    refr_t            refr      [N_NEURONS];
    logic [WIDTH-1:0] threshold [N_NEURONS];

    logic [WIDTH-1:0] mem_nxt;
    refr_t            refr_nxt;
    logic             fire;

    lif_update #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRACT    (REFRACT)
    ) u_update (
        .mem      (membrane[bus.slot]),
        .refr     (refr[bus.slot]),
        .thresh   (threshold[bus.slot]),
        .current  (bus.current),
        .mem_nxt  (mem_nxt),
        .refr_nxt (refr_nxt),
        .fire     (fire)
    );

    // Write back the visited neuron and advance the sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                membrane[i] <= '0;
                refr[i]     <= '0;
            end
            bus.spike      <= '0;
            bus.slot       <= '0;
            bus.sweep_done <= 1'b0;
        end else begin
            bus.sweep_done <= bus.en && (bus.slot == SLOT_W'(N_NEURONS - 1));
            if (bus.en) begin
                membrane[bus.slot]  <= mem_nxt;
                refr[bus.slot]      <= refr_nxt;
                bus.spike[bus.slot] <= fire;
                bus.slot            <= bus.slot + SLOT_W'(1);
            end
        end
    end

    // Threshold writes land regardless of en; a write to the slot being
    // visited only takes effect on that neuron's following visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                threshold[i] <= WIDTH'(THRESH_RST);
            end
        end else if (bus.cfg_we) begin
            threshold[bus.cfg_addr] <= bus.cfg_thresh;
        end
    end

endmodule

// File: tb/tb_tm_lif_array.sv
// Directed self-checking bench for tm_lif_array with default parameters.
module tb_tm_lif_array;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tm_lif_array_if #(.N_NEURONS(8), .WIDTH(8)) bus ();

    tm_lif_array #(
        .N_NEURONS  (8),
        .WIDTH      (8),
        .LEAK_SHIFT (1),
        .REFRACT    (2),
        .THRESH_RST (127)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic tick(input logic en_v, input logic [7:0] cur);
        bus.en      = en_v;
        bus.current = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.current = '0; bus.cfg_we = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.spike !== 8'h00) begin
            errors++; $display("FAIL reset_spike got %h want 00", bus.spike);
        end
        checks++;
        if (bus.slot !== 3'd0) begin
            errors++; $display("FAIL reset_slot got %0d want 0", bus.slot);
        end
        checks++;
        if (bus.sweep_done !== 1'b0) begin
            errors++; $display("FAIL reset_sweep_done got %b want 0", bus.sweep_done);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.threshold[i] !== 8'd127) begin
                errors++; $display("FAIL reset_thresh[%0d] got %0d want 127", i, dut.threshold[i]);
            end
        end
    endtask

    task automatic test_integrate();
        logic [7:0] exp_mem [10];
        logic       exp_spk [10];
        exp_mem = '{8'd64, 8'd96, 8'd112, 8'd120, 8'd124, 8'd126, 8'd0, 8'd0, 8'd0, 8'd64};
        exp_spk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int v = 0; v < 10; v++) begin
            for (int s = 0; s < 8; s++) begin
                tick(1'b1, 8'd64);
                if (s == 0) begin
                    checks++;
                    if (dut.membrane[0] !== exp_mem[v]) begin
                        errors++; $display("FAIL integ_mem visit %0d got %0d want %0d", v + 1, dut.membrane[0], exp_mem[v]);
                    end
                    checks++;
                    if (bus.spike[0] !== exp_spk[v]) begin
                        errors++; $display("FAIL integ_spike visit %0d got %b want %b", v + 1, bus.spike[0], exp_spk[v]);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd3; bus.cfg_thresh = 8'd255;
        tick(1'b0, 8'd0);
        bus.cfg_we = 1'b0;
        for (int s = 0; s < 8; s++) begin
            tick(1'b1, (s == 3) ? 8'd200 : 8'd0);
            if (s == 3) begin
                checks++;
                if (dut.membrane[3] !== 8'd200 || bus.spike[3] !== 1'b0) begin
                    errors++; $display("FAIL sat_load mem %0d spike %b want mem 200 spike 0", dut.membrane[3], bus.spike[3]);
                end
            end
        end
        for (int s = 0; s < 8; s++) begin
            tick(1'b1, (s == 3) ? 8'd255 : 8'd0);
            if (s == 3) begin
                checks++;
                if (bus.spike[3] !== 1'b1) begin
                    errors++; $display("FAIL sat_spike got %b want 1", bus.spike[3]);
                end
                checks++;
                if (dut.membrane[3] !== 8'd0) begin
                    errors++; $display("FAIL sat_mem got %0d want 0", dut.membrane[3]);
                end
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        tick(1'b1, 8'd0);
        tick(1'b1, 8'd0);
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_thresh = 8'd10;
        tick(1'b1, 8'd20);
        bus.cfg_we = 1'b0;
        checks++;
        if (bus.spike[2] !== 1'b0 || dut.membrane[2] !== 8'd20) begin
            errors++; $display("FAIL coll_old_thresh spike %b mem %0d want spike 0 mem 20", bus.spike[2], dut.membrane[2]);
        end
        checks++;
        if (dut.threshold[2] !== 8'd10) begin
            errors++; $display("FAIL coll_thresh_written got %0d want 10", dut.threshold[2]);
        end
        for (int s = 3; s < 10; s++) tick(1'b1, 8'd0);
        tick(1'b1, 8'd20);
        checks++;
        if (bus.spike[2] !== 1'b1 || dut.membrane[2] !== 8'd0) begin
            errors++; $display("FAIL coll_new_thresh spike %b mem %0d want spike 1 mem 0", bus.spike[2], dut.membrane[2]);
        end
    endtask

    task automatic test_enable_strobe();
        int exp_slot;
        int pulses;
        do_reset();
        for (int s = 0; s < 3; s++) tick(1'b1, 8'd5);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 8'd100);
            checks++;
            if (bus.slot !== 3'd3 || bus.sweep_done !== 1'b0 || bus.spike !== 8'h00) begin
                errors++; $display("FAIL en_freeze cyc %0d slot %0d sd %b spike %h want 3 0 00", c, bus.slot, bus.sweep_done, bus.spike);
            end
            checks++;
            if (dut.membrane[2] !== 8'd5 || dut.membrane[3] !== 8'd0) begin
                errors++; $display("FAIL en_freeze_mem m2 %0d m3 %0d want 5 0", dut.membrane[2], dut.membrane[3]);
            end
        end
        exp_slot = 3;
        pulses   = 0;
        for (int c = 0; c < 13; c++) begin
            tick(1'b1, 8'd0);
            if (bus.sweep_done === 1'b1) pulses++;
            checks++;
            if (bus.sweep_done !== (exp_slot == 7)) begin
                errors++; $display("FAIL strobe cyc %0d got %b want %b", c, bus.sweep_done, exp_slot == 7);
            end
            exp_slot = (exp_slot + 1) % 8;
        end
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL strobe_count got %0d want 2", pulses);
        end
        tick(1'b0, 8'd0);
        checks++;
        if (bus.sweep_done !== 1'b0 || bus.slot !== 3'd0) begin
            errors++; $display("FAIL strobe_en_low sd %b slot %0d want 0 0", bus.sweep_done, bus.slot);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_thresh = 8'd50;
        tick(1'b0, 8'd0);
        bus.cfg_we = 1'b0;
        for (int s = 0; s < 5; s++) tick(1'b1, 8'd200);
        checks++;
        if (bus.spike !== 8'h1F || bus.slot !== 3'd5) begin
            errors++; $display("FAIL arst_pre spike %h slot %0d want 1f 5", bus.spike, bus.slot);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.spike !== 8'h00 || bus.slot !== 3'd0 || bus.sweep_done !== 1'b0) begin
            errors++; $display("FAIL arst_out spike %h slot %0d sd %b want 00 0 0", bus.spike, bus.slot, bus.sweep_done);
        end
        checks++;
        if (dut.threshold[1] !== 8'd127 || dut.refr[0] !== 4'd0) begin
            errors++; $display("FAIL arst_state thr1 %0d refr0 %0d want 127 0", dut.threshold[1], dut.refr[0]);
        end
        rst_n = 1'b1;
        tick(1'b1, 8'd0);
        checks++;
        if (bus.slot !== 3'd1 || dut.membrane[0] !== 8'd0) begin
            errors++; $display("FAIL arst_restart slot %0d mem0 %0d want 1 0", bus.slot, dut.membrane[0]);
        end
    endtask

    task automatic test_decay();
        logic [7:0] exp_mem [8];
        exp_mem = '{8'd60, 8'd30, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0, 8'd0};
        do_reset();
        tick(1'b1, 8'd120);
        checks++;
        if (dut.membrane[0] !== 8'd120) begin
            errors++; $display("FAIL decay_load got %0d want 120", dut.membrane[0]);
        end
        for (int s = 1; s < 8; s++) tick(1'b1, 8'd0);
        for (int v = 0; v < 8; v++) begin
            for (int s = 0; s < 8; s++) begin
                tick(1'b1, 8'd0);
                if (s == 0) begin
                    checks++;
                    if (dut.membrane[0] !== exp_mem[v] || bus.spike[0] !== 1'b0) begin
                        errors++; $display("FAIL decay visit %0d mem %0d spike %b want %0d 0", v + 1, dut.membrane[0], bus.spike[0], exp_mem[v]);
                    end
                end
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.current    = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_thresh = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_integrate();
        test_saturation();
        test_collision();
        test_enable_strobe();
        test_async_reset();
        test_decay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm_lif_array.md
Name: tm_lif_array

Overview:
Parametrised time-multiplexed leaky-integrate-and-fire neuron array. A single shared update datapath sweeps N_NEURONS membrane registers round-robin, one neuron per enabled clock.
Adds several features:
- per-neuron programmable thresholds
- configurable leak
- saturating integration
- reset-to-zero on fire
- a refractory period
- a sweep-complete strobe
It sits between the input current source and downstream spike consumers in the SNN demo datapath.

Parameters:
N_NEURONS, 8, number of neurons (power of two, 2..64)
WIDTH, 8, membrane/current/threshold width in bits
LEAK_SHIFT, 1, leak = right shift of membrane per visit (0..WIDTH-1)
REFRACT, 2, visits a neuron stays silent after firing (0..15)
THRESH_RST, 127, threshold value loaded at reset for all neurons

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  advance sweep; when low, all state holds
current  in  WIDTH  input current applied to the neuron being visited
cfg_we  in  1  threshold write strobe
cfg_addr  in  $clog2(N_NEURONS)  neuron index for threshold write
cfg_thresh  in  WIDTH  threshold value to write
spike  out  N_NEURONS  registered spike flags, bit i valid from visit i until next visit i
slot  out  $clog2(N_NEURONS)  index of neuron updated on next enabled edge
sweep_done  out  1  one-cycle pulse registered on the edge that updates neuron N_NEURONS-1

Behaviour:
- Reset (async, rst_n low) values:
  - membrane[*]=0, refr[*]=0, threshold[*]=THRESH_RST
  - spike=0, slot=0, sweep_done=0
- Each rising clk with en=1: neuron i=slot is updated, then slot<=slot+1 (wraps N_NEURONS-1 -> 0).
- en=0: no membrane, refr, spike or slot change; sweep_done<=0. cfg writes still occur.
- Update of neuron i, using values before the edge:
  - if refr[i]!=0: membrane[i]<=0, refr[i]<=refr[i]-1, spike[i]<=0.
  - else sum = current + (membrane[i] >> LEAK_SHIFT), computed at WIDTH+1 bits, saturated to 2^WIDTH-1.
    - if sum >= threshold[i] (unsigned): spike[i]<=1, membrane[i]<=0, refr[i]<=REFRACT.
    - else: spike[i]<=0, membrane[i]<=sum.
- Latency: spike[i] is visible the cycle after neuron i's visit and holds for N_NEURONS enabled cycles.
- Only bit slot of spike changes per edge.
- sweep_done<=1 exactly when en=1 and slot==N_NEURONS-1, otherwise 0.
- Threshold write: on edge with cfg_we=1, threshold[cfg_addr]<=cfg_thresh.
  - If cfg_addr==slot on that edge, the compare uses the OLD threshold; the new value applies from the next visit.
- REFRACT=0: a neuron may fire on consecutive visits.
- current=0 with LEAK_SHIFT>=1: membrane decays monotonically to 0.
- LEAK_SHIFT=0: no leak, pure saturating integrator.
- Reset asserted mid-sweep: all state is cleared immediately and the sweep restarts from slot 0 after release.
- Storage: membrane/refr/threshold are register arrays, not RAM. No combinational path from inputs to outputs.

Decomposition:
- Package tm_lif_pkg holds:
  - default constants: WIDTH, N_NEURONS, THRESH_RST
  - function sat_add(a,b) for the saturating WIDTH+1 add
  - typedef for the refractory counter (4 bits)
- One sub-module, lif_update: purely combinational per-neuron update.
  - Inputs: membrane, refr, threshold, current.
  - Outputs: next membrane, next refr, fire.
  - Instanced once and muxed by slot.

Test Plan:
1. Integration to fire: defaults, current=64 constant, en=1.
   - Neuron 0 membrane after visits 1..6 = 64, 96, 112, 120, 124, 126.
   - Visit 7: spike[0]=1, membrane 0.
   - Visits 8-9: spike[0]=0 (refractory).
   - Visit 10: membrane=64.
2. Saturation: threshold[3]=255 via cfg, membrane[3] driven to 200, then current=255.
   - sum saturates to 255 >= 255 -> spike[3]=1, membrane 0.
   - No wrap to 99.
3. Threshold write collision: cfg_we with cfg_addr=slot=2, cfg_thresh=10, current=20, membrane 0.
   - Compare uses old 127 -> no spike.
   - Next visit of neuron 2: sum=30 >= 10 -> spike[2]=1.
4. Enable and strobe: toggle en low for 5 cycles mid-sweep.
   - slot, spike and membranes are frozen.
   - sweep_done pulses once per 8 enabled cycles, never while en=0.
5. Async reset mid-operation: assert rst_n between edges during sweep slot 5.
   - spike=0, slot=0, all thresholds=127 immediately without a clock edge.
6. Decay: load membrane 120, then current=0.
   - Successive visits give 60, 30, 15, 7, 3, 1, 0, 0; no spikes.
